// File: rtl/i4003x_if.sv
// Shift-register bus: shift clock, serial data, and output enable from the driver;
// parallel word, chain output, and word status from the register.
interface i4003x_if #(
  parameter int unsigned WIDTH = 10
);
  logic                     cp;
  logic                     serial_in;
  logic                     enable;
  logic [WIDTH-1:0]         parallel_out;
  logic                     serial_out;
  logic                     word_done;
  logic [$clog2(WIDTH)-1:0] shift_count;

  modport master (
    output cp, serial_in, enable,
    input  parallel_out, serial_out, word_done, shift_count
  );

  modport slave (
    input  cp, serial_in, enable,
    output parallel_out, serial_out, word_done, shift_count
  );
endinterface

// File: rtl/i4003x.sv
// Parametrised serial-in/parallel-out shift register for MCS-4 output expansion.
// cp is edge-detected in the sysclk domain; optional holding register gives word-stable outputs.
module i4003x #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned DIR        = 0,
  parameter int unsigned LATCH_MODE = 0
) (
  input logic     sysclk,
  input logic     reset,
  i4003x_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic             cp_q;
  logic [WIDTH-1:0] sr_q, sr_d, src;
  logic [CW-1:0]    count_q;
  logic             done_q;
  logic             strobe;
  logic             last;

  assign strobe = bus.cp & ~cp_q;
  assign last   = (count_q == CW'(WIDTH - 1));

  always_comb begin
    if (DIR != 0) sr_d = {bus.serial_in, sr_q[WIDTH-1:1]};
    else          sr_d = {sr_q[WIDTH-2:0], bus.serial_in};
  end

  // cp_q resets high so a cp held high through reset release does not shift.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cp_q    <= 1'b1;
      sr_q    <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cp_q   <= bus.cp;
      done_q <= 1'b0;
      if (strobe) begin
        sr_q <= sr_d;
        if (last) begin
          count_q <= '0;
          done_q  <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  if (LATCH_MODE != 0) begin : g_hold
    logic [WIDTH-1:0] hold_q;

    // Capture includes the bit shifted on the completing edge.
    always_ff @(posedge sysclk) begin
      if (reset)               hold_q <= '0;
      else if (strobe && last) hold_q <= sr_d;
    end

    assign src = hold_q;
  end else begin : g_transparent
    assign src = sr_q;
  end

  assign bus.parallel_out = bus.enable ? src : '0;
  assign bus.serial_out   = (DIR != 0) ? sr_q[0] : sr_q[WIDTH-1];
  assign bus.word_done    = done_q;
  assign bus.shift_count  = count_q;
endmodule

// File: tb/tb_i4003x.sv
// Bench for i4003x: three configurations driven in lockstep and checked against a
// bit-history model, plus directed vectors and corner sequences.
module tb_i4003x;
  localparam int unsigned W = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cp = 1'b1;
  logic serial_in = 1'b0;
  logic enable = 1'b1;

  int total = 0;
  int bad = 0;

  // Model: every bit shifted since the last reset, oldest first.
  bit hist[$];
  bit m_cp_prev = 1'b1;
  bit m_done = 1'b0;

  typedef struct {
    bit         sin;
    logic [9:0] po0;
    logic [9:0] po1;
    int         cnt;
    bit         wd;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  i4003x_if #(.WIDTH(W)) if0 ();
  i4003x_if #(.WIDTH(W)) if1 ();
  i4003x_if #(.WIDTH(W)) if2 ();

  assign if0.cp = cp;
  assign if0.serial_in = serial_in;
  assign if0.enable = enable;
  assign if1.cp = cp;
  assign if1.serial_in = serial_in;
  assign if1.enable = enable;
  assign if2.cp = cp;
  assign if2.serial_in = serial_in;
  assign if2.enable = enable;

  i4003x #(.WIDTH(W), .DIR(0), .LATCH_MODE(0)) dut0 (.sysclk(clk), .reset(reset), .bus(if0));
  i4003x #(.WIDTH(W), .DIR(1), .LATCH_MODE(0)) dut1 (.sysclk(clk), .reset(reset), .bus(if1));
  i4003x #(.WIDTH(W), .DIR(0), .LATCH_MODE(1)) dut2 (.sysclk(clk), .reset(reset), .bus(if2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register contents after the first m shifts of the history.
  function automatic logic [W-1:0] model_word(input int m, input bit dir);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(W) && i < m; i++) begin
      if (dir) v[W-1-i] = hist[m-1-i];
      else     v[i]     = hist[m-1-i];
    end
    return v;
  endfunction

  task automatic model_edge(input bit r, input bit c, input bit s);
    if (r) begin
      hist.delete();
      m_cp_prev = 1'b1;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (c && !m_cp_prev) begin
        hist.push_back(s);
        if (hist.size() % W == 0) m_done = 1'b1;
      end
      m_cp_prev = c;
    end
  endtask

  task automatic check_all();
    int n;
    logic [W-1:0] s0, s1, h2;
    n = hist.size();
    s0 = model_word(n, 1'b0);
    s1 = model_word(n, 1'b1);
    h2 = model_word(n - (n % int'(W)), 1'b0);
    check("dut0 parallel_out", 32'(if0.parallel_out), 32'(enable ? s0 : '0));
    check("dut1 parallel_out", 32'(if1.parallel_out), 32'(enable ? s1 : '0));
    check("dut2 parallel_out", 32'(if2.parallel_out), 32'(enable ? h2 : '0));
    check("dut0 serial_out", 32'(if0.serial_out), 32'(s0[W-1]));
    check("dut1 serial_out", 32'(if1.serial_out), 32'(s1[0]));
    check("dut2 serial_out", 32'(if2.serial_out), 32'(s0[W-1]));
    check("dut0 word_done", 32'(if0.word_done), 32'(m_done));
    check("dut1 word_done", 32'(if1.word_done), 32'(m_done));
    check("dut2 word_done", 32'(if2.word_done), 32'(m_done));
    check("dut0 shift_count", 32'(if0.shift_count), 32'(n % int'(W)));
    check("dut1 shift_count", 32'(if1.shift_count), 32'(n % int'(W)));
    check("dut2 shift_count", 32'(if2.shift_count), 32'(n % int'(W)));
  endtask

  // Inputs change at negedge; DUT samples at posedge; outputs checked at the next negedge.
  task automatic step(input bit r, input bit c, input bit s, input bit e);
    reset = r;
    cp = c;
    serial_in = s;
    enable = e;
    @(posedge clk);
    model_edge(r, c, s);
    @(negedge clk);
    check_all();
  endtask

  task automatic shift(input bit s, input bit e);
    step(1'b0, 1'b0, s, e);
    step(1'b0, 1'b1, s, e);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic [9:0] pat_a;
    logic [9:0] pat_b;
    int wd_seen;

    tbl[0] = '{1'b1, 10'h001, 10'h200, 1, 1'b0};
    tbl[1] = '{1'b0, 10'h002, 10'h100, 2, 1'b0};
    tbl[2] = '{1'b0, 10'h004, 10'h080, 3, 1'b0};
    tbl[3] = '{1'b0, 10'h008, 10'h040, 4, 1'b0};
    tbl[4] = '{1'b0, 10'h010, 10'h020, 5, 1'b0};
    tbl[5] = '{1'b0, 10'h020, 10'h010, 6, 1'b0};
    tbl[6] = '{1'b0, 10'h040, 10'h008, 7, 1'b0};
    tbl[7] = '{1'b0, 10'h080, 10'h004, 8, 1'b0};
    tbl[8] = '{1'b0, 10'h100, 10'h002, 9, 1'b0};
    tbl[9] = '{1'b0, 10'h200, 10'h001, 0, 1'b1};

    @(negedge clk);
    // cp held high across reset release: no shift.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("release shift_count", 32'(if0.shift_count), 32'd0);
    check("release parallel_out", 32'(if0.parallel_out), 32'h0);
    check("release serial_out", 32'(if0.serial_out), 32'd0);

    // One then nine zeros, both directions.
    for (int k = 0; k < 10; k++) begin
      shift(tbl[k].sin, 1'b1);
      check("vec dir0 parallel_out", 32'(if0.parallel_out), 32'(tbl[k].po0));
      check("vec dir1 parallel_out", 32'(if1.parallel_out), 32'(tbl[k].po1));
      check("vec shift_count", 32'(if0.shift_count), 32'(tbl[k].cnt));
      check("vec word_done", 32'(if0.word_done), 32'(tbl[k].wd));
      check("vec dir0 serial_out", 32'(if0.serial_out), 32'(k == 9));
      check("vec dir1 serial_out", 32'(if1.serial_out), 32'(k == 9));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("word_done single pulse", 32'(if0.word_done), 32'd0);

    // Holding register: stable until the next word completes.
    do_reset();
    pat_a = 10'h155;
    pat_b = 10'h2aa;
    for (int i = 9; i >= 0; i--) begin
      shift(pat_a[i], 1'b1);
      if (i == 1) check("latch before word", 32'(if2.parallel_out), 32'h0);
    end
    check("latch first word", 32'(if2.parallel_out), 32'h155);
    check("latch word_done", 32'(if2.word_done), 32'd1);
    for (int i = 9; i >= 5; i--) shift(pat_b[i], 1'b1);
    check("latch mid word held", 32'(if2.parallel_out), 32'h155);
    for (int i = 4; i >= 0; i--) shift(pat_b[i], 1'b1);
    check("latch second word", 32'(if2.parallel_out), 32'h2aa);

    // Outputs gated for a full word; enable raise is combinational.
    for (int i = 0; i < 10; i++) begin
      shift(1'($urandom), 1'b0);
      check("disabled parallel_out", 32'(if0.parallel_out), 32'h0);
    end
    enable = 1'b1;
    #1;
    check("enable raise dir0", 32'(if0.parallel_out), 32'(model_word(hist.size(), 1'b0)));
    check("enable raise latch", 32'(if2.parallel_out),
          32'(model_word(hist.size() - (hist.size() % W), 1'b0)));
    @(negedge clk);

    // Reset mid-word discards the partial word.
    for (int i = 0; i < 4; i++) shift(1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("midreset shift_count", 32'(if0.shift_count), 32'd0);
    check("midreset parallel_out", 32'(if0.parallel_out), 32'h0);
    wd_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      shift(1'b1, 1'b1);
      if (if0.word_done) wd_seen++;
      if (i == 6) check("midreset no done at 6", 32'(if0.word_done), 32'd0);
      if (i == 10) check("midreset done at 10", 32'(if0.word_done), 32'd1);
    end
    check("midreset done count", 32'(wd_seen), 32'd1);

    // Reset coinciding with a strobe wins.
    shift(1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("reset vs strobe count", 32'(if0.shift_count), 32'd0);
    check("reset vs strobe parallel", 32'(if0.parallel_out), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
